// File: rtl/capture_fifo.sv
// capture_fifo: queues timer captures in a DEPTH-entry FIFO behind a 4-register bus window,
// with sticky over/underflow flags, a saturating drop counter and a registered level interrupt.
module capture_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cap_valid,
  input  logic [DW-1:0] cap_data,
  output logic          cap_ren,
  input  logic          ren,
  input  logic          wen,
  input  logic [1:0]    add,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic          r_cap_d, r_rd_d, r_en, r_irq_en, r_ovf, r_unf, r_irq;
  logic [7:0]    r_thr;
  logic [15:0]   r_drop;
  logic [31:0]   r_rdata;

  logic        w_empty, w_full, w_push_ev, w_pop_ev, w_do_push, w_do_pop, w_drop;
  logic        w_ctrl_wr, w_clr, w_fclr_wr, w_rd_upd, w_unused;
  logic [31:0] w_status, w_ctrl, w_rd_mux;

  assign w_empty   = r_count == '0;
  assign w_full    = r_count == CW'(DEPTH);
  assign w_push_ev = r_en & cap_valid & ~r_cap_d;
  // a held DATA read pops only on its first cycle
  assign w_pop_ev  = ren & (add == 2'd0) & ~r_rd_d;
  assign w_do_pop  = w_pop_ev & ~w_empty;
  assign w_do_push = w_push_ev & (~w_full | w_do_pop);
  assign w_drop    = w_push_ev & ~w_do_push;
  assign w_ctrl_wr = wen & (add == 2'd2);
  assign w_clr     = w_ctrl_wr & wdata[2];
  assign w_fclr_wr = wen & (add == 2'd3);
  assign w_rd_upd  = ren & ((add != 2'd0) | w_pop_ev);
  assign w_status  = {r_drop, 8'(r_count), 4'b0, r_unf, r_ovf, w_full, w_empty};
  assign w_ctrl    = {16'b0, r_thr, 6'b0, r_irq_en, r_en};
  assign w_unused  = &{1'b0, wdata[31:16], wdata[7:4]};

  always_comb begin
    w_rd_mux = add == 2'd0 ? (w_do_pop ? 32'(r_mem[r_head]) : 32'd0) :
               add == 2'd1 ? w_status :
               add == 2'd2 ? w_ctrl : 32'd0;
  end

  always_ff @(posedge clk)
    if (w_do_push) r_mem[r_tail] <= cap_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_cap_d  <= 1'b0;
      r_rd_d   <= 1'b0;
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_thr    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_drop   <= '0;
      r_rdata  <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_cap_d <= cap_valid;
      r_rd_d  <= ren & (add == 2'd0);
      if (w_rd_upd) r_rdata <= w_rd_mux;
      r_irq <= r_irq_en & (r_ovf | ((r_thr != 8'd0) & (8'(r_count) >= r_thr)));
      if (w_ctrl_wr) {r_thr, r_irq_en, r_en} <= {wdata[15:8], wdata[1:0]};
      if (w_clr) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
        r_unf   <= 1'b0;
        r_drop  <= '0;
      end else begin
        if (w_do_push) r_tail <= r_tail + AW'(1);
        if (w_do_pop) r_head <= r_head + AW'(1);
        r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        // set beats a coincident FLAGS_CLR write
        r_ovf <= w_drop | (r_ovf & ~(w_fclr_wr & wdata[2]));
        r_unf <= (w_pop_ev & w_empty) | (r_unf & ~(w_fclr_wr & wdata[3]));
        if (w_drop & ~&r_drop) r_drop <= r_drop + 16'd1;
      end
    end
  end

  assign cap_ren = w_push_ev;
  assign rdata   = r_rdata;
  assign irq     = r_irq;
endmodule
